qracc_adc_readout: RTL and testbench
====================================

Name: qracc_adc_readout

Overview:
- Downstream stage of the multibank QR-accelerator macro; consumes its flat thermometer ADC bus of compCount*numCols*numBanks bits.
- On a sample strobe, snapshots the whole bus and converts each column's thermometer code to binary by popcount.
- Streams the results one bank per beat over a valid/ready interface, skipping banks masked off at capture.
- Flags thermometer bubbles per column and sample overruns.

Parameters:
- numCols, 8, columns per bank.
- numAdcBits, 4, ADC resolution; binary output width per column.
- numBanks, 8, number of banks on the ADC bus.
- compCount, (2**numAdcBits)-1, localparam; comparators per column.
- bankIdxW, $clog2(numBanks) (min 1), localparam; width of the bank index.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ADC_OUT  in  compCount*numCols*numBanks  thermometer bus. Bit j of column c, bank b is at index (b*numCols+c)*compCount+j; j=0 is the lowest threshold.
- adc_sample  in  1  single-cycle strobe; ADC_OUT is valid this cycle.
- bank_en  in  numBanks  bank mask, captured with the sample.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  numCols*numAdcBits  binary codes; column c occupies [c*numAdcBits +: numAdcBits].
- out_bubble  out  numCols  bit c set if column c's code is non-monotonic.
- out_bank  out  bankIdxW  bank index of the current beat.
- out_last  out  1  current beat is the last enabled bank of the frame.
- frame_done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  frame in progress.
- overrun  out  1  sticky; a sample was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset values: all outputs 0; snapshot register 0; state IDLE.
- State IDLE:
  - Sample with bank_en != 0: capture ADC_OUT and bank_en into snapshot registers. Next cycle enter STREAM, out_bank = lowest enabled bank, out_valid = 1. Latency from strobe to first valid is 1 cycle.
  - Sample with bank_en == 0: no beats; frame_done pulses the next cycle; stay IDLE.
- State STREAM:
  - out_data, out_bubble, out_bank and out_last are held stable while out_valid && !out_ready.
  - On a handshake (out_valid && out_ready) that is not the last beat: advance to the next higher enabled bank the next cycle.
  - On the last-beat handshake: frame_done pulses the next cycle and the state returns to IDLE, unless a new sample is accepted in the same cycle (see below).
  - busy = 1 in STREAM.
- Acceptance of adc_sample:
  - Accepted when IDLE, or in the cycle of the last-beat handshake. In the latter case the next frame starts with no bubble cycle: out_valid stays 1 and frame_done still pulses.
  - A sample in any other cycle is dropped, the snapshot is untouched, and overrun is set.
  - If clr_overrun and a drop occur in the same cycle, set wins.
- Conversion:
  - Binary code = popcount of the column's compCount bits; range 0..compCount, fits in numAdcBits.
  - Bubble = the code is not of the form 2^n - 1 (i.e. some bit j is 1 while a lower bit is 0). The popcount is still output.
  - Conversion is combinational from the snapshot for the selected bank; there is no extra pipeline stage.
- Bank order: ascending index; disabled banks are never emitted.
- out_last is combinational: no enabled bank above the current index.
- Reset asserted mid-frame aborts the frame immediately, with no frame_done.
- ADC_OUT is sampled only on an accepted strobe; changes between strobes are ignored.

Decomposition:
- Package qracc_readout_pkg:
  - state enum {IDLE, STREAM};
  - function next_enabled_bank(mask, cur);
  - compCount helper constant.
- Sub-module qracc_therm2bin: one column, compCount-bit input, produces the popcount and bubble flag. Instantiated numCols times behind a bank mux on the snapshot.

Test Plan:
- Single frame: bank_en=8'hFF, bank b column c has code min(b+c, 15) as a clean thermometer, out_ready=1.
  - Expect 8 consecutive beats, banks 0..7, out_data column c = min(b+c, 15).
  - out_last only on bank 7; frame_done pulses one cycle after.
- Backpressure with mask: bank_en=8'b1010_0100, out_ready toggling 1/0.
  - Beats for banks 2, 5, 7 only; data held stable during stalls; out_last on bank 7.
- Empty mask: bank_en=0 → no out_valid; frame_done pulses 1 cycle after the strobe; busy stays 0.
- Bubble: a column driven with 15'b000_0000_0000_0101 → code 2, out_bubble bit set.
  - All-ones column → code 15, no bubble. All-zeros column → code 0, no bubble.
- Overrun and back-to-back:
  - A strobe during beat 3 of 8 → overrun=1; the frame continues unchanged with the original data.
  - A strobe coincident with the last handshake → the new frame's bank 0 beat appears the next cycle with no gap.
  - clr_overrun → overrun=0.
- Reset mid-frame: nRST low during beat 4 → out_valid, busy and overrun are 0 immediately with no frame_done; the next strobe after release behaves normally.

Source files
------------

// File: rtl/qracc_readout_pkg.sv
// Shared types and helpers for the QR-accelerator ADC readout stage.
//   state_e           : readout FSM states
//   comp_count()      : comparators per column for a given ADC resolution
//   next_enabled_bank : lowest set mask bit at or above a start index
package qracc_readout_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Bank search works on a fixed-width mask so one helper serves any numBanks <= MAX_BANKS.
    localparam int unsigned MAX_BANKS     = 64;
    localparam int unsigned BANK_SEARCH_W = 7;

    function automatic int unsigned comp_count(input int unsigned adc_bits);
        return (32'd1 << adc_bits) - 32'd1;
    endfunction

    // Returns the lowest enabled bank index >= cur, or MAX_BANKS when none exists.
    function automatic logic [BANK_SEARCH_W-1:0] next_enabled_bank(
        input logic [MAX_BANKS-1:0]     mask,
        input logic [BANK_SEARCH_W-1:0] cur
    );
        logic [BANK_SEARCH_W-1:0] res;
        res = BANK_SEARCH_W'(MAX_BANKS);
        for (int i = MAX_BANKS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(cur))) begin
                res = BANK_SEARCH_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/qracc_therm2bin.sv
// Thermometer-to-binary converter for one ADC column.
//   therm_i  : COMP_COUNT comparator outputs, bit 0 is the lowest threshold
//   code_o   : popcount of therm_i
//   bubble_o : set when a comparator fires while a lower one does not
module qracc_therm2bin #(
    parameter int unsigned COMP_COUNT = 15,
    parameter int unsigned ADC_BITS   = 4
) (
    input  logic [COMP_COUNT-1:0] therm_i,
    output logic [ADC_BITS-1:0]   code_o,
    output logic                  bubble_o
);

    // Popcount keeps the converter tolerant of bubbles; the flag reports them separately.
    always_comb begin
        code_o   = '0;
        bubble_o = 1'b0;
        for (int unsigned j = 0; j < COMP_COUNT; j++) begin
            code_o = code_o + ADC_BITS'(therm_i[j]);
        end
        for (int unsigned j = 1; j < COMP_COUNT; j++) begin
            if (therm_i[j] && !therm_i[j-1]) begin
                bubble_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qracc_adc_readout.sv
// Readout stage for the multibank QR-accelerator ADC bus.
// Snapshots the thermometer bus on an accepted strobe and streams one enabled bank
// per valid/ready beat in ascending order, with per-column bubble flags.
//   CLK, nRST              : clock, async active-low reset
//   ADC_OUT, adc_sample    : thermometer bus and its single-cycle strobe
//   bank_en                : bank mask captured with the strobe
//   out_valid/out_ready    : beat handshake
//   out_data/out_bubble    : binary codes and bubble flags of the current bank
//   out_bank/out_last      : current bank index / last enabled bank of the frame
//   frame_done, busy       : frame completion pulse, frame in progress
//   overrun, clr_overrun   : sticky dropped-strobe flag and its clear
module qracc_adc_readout
    import qracc_readout_pkg::*;
#(
    parameter int unsigned numCols    = 8,
    parameter int unsigned numAdcBits = 4,
    parameter int unsigned numBanks   = 8
) (
    input  logic                                                   CLK,
    input  logic                                                   nRST,
    input  logic [comp_count(numAdcBits)*numCols*numBanks-1:0]     ADC_OUT,
    input  logic                                                   adc_sample,
    input  logic [numBanks-1:0]                                    bank_en,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [numCols*numAdcBits-1:0]                          out_data,
    output logic [numCols-1:0]                                     out_bubble,
    output logic [((numBanks > 1) ? $clog2(numBanks) : 1)-1:0]     out_bank,
    output logic                                                   out_last,
    output logic                                                   frame_done,
    output logic                                                   busy,
    output logic                                                   overrun,
    input  logic                                                   clr_overrun
);

    localparam int unsigned compCount = comp_count(numAdcBits);
    localparam int unsigned bankIdxW  = (numBanks > 1) ? $clog2(numBanks) : 1;
    localparam int unsigned BANK_BITS = compCount * numCols;
    localparam int unsigned BUS_W     = BANK_BITS * numBanks;

    state_e                   state_q;
    logic [BUS_W-1:0]         snap_q;
    logic [numBanks-1:0]      mask_q;
    logic [bankIdxW-1:0]      bank_q;
    logic                     frame_done_q;
    logic                     overrun_q;

    logic [MAX_BANKS-1:0]     mask_ext_q;
    logic [MAX_BANKS-1:0]     mask_ext_in;
    logic [BANK_SEARCH_W-1:0] first_en;
    logic [BANK_SEARCH_W-1:0] above_cur;
    logic                     last_c;
    logic                     hs;
    logic                     last_hs;
    logic                     accept;
    logic                     drop;
    logic [BANK_BITS-1:0]     bank_bits;

    // Handshake and strobe-acceptance decode.
    always_comb begin
        mask_ext_q  = MAX_BANKS'(mask_q);
        mask_ext_in = MAX_BANKS'(bank_en);
        first_en    = next_enabled_bank(mask_ext_in, '0);
        above_cur   = next_enabled_bank(mask_ext_q, BANK_SEARCH_W'(bank_q) + BANK_SEARCH_W'(1));
        last_c      = (above_cur >= BANK_SEARCH_W'(numBanks));
        hs          = out_valid && out_ready;
        last_hs     = hs && last_c;
        // A strobe on the final handshake chains straight into the next frame.
        accept      = adc_sample && ((state_q == IDLE) || last_hs);
        drop        = adc_sample && !accept;
    end

    assign out_valid  = (state_q == STREAM);
    assign busy       = (state_q == STREAM);
    assign out_bank   = bank_q;
    assign out_last   = out_valid && last_c;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

    // Bank mux on the snapshot feeding the per-column converters.
    assign bank_bits = snap_q[32'(bank_q)*BANK_BITS +: BANK_BITS];

    for (genvar c = 0; c < numCols; c++) begin : g_col
        qracc_therm2bin #(
            .COMP_COUNT (compCount),
            .ADC_BITS   (numAdcBits)
        ) u_therm2bin (
            .therm_i  (bank_bits[c*compCount +: compCount]),
            .code_o   (out_data[c*numAdcBits +: numAdcBits]),
            .bubble_o (out_bubble[c])
        );
    end

    // Readout FSM, snapshot capture and status flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            mask_q       <= '0;
            bank_q       <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= last_hs || (accept && (bank_en == '0));

            // Drop wins over a simultaneous clear.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end

            if (accept) begin
                snap_q <= ADC_OUT;
                mask_q <= bank_en;
            end

            case (state_q)
                IDLE: begin
                    if (accept && (bank_en != '0)) begin
                        state_q <= STREAM;
                        bank_q  <= bankIdxW'(first_en);
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (!last_c) begin
                            bank_q <= bankIdxW'(above_cur);
                        end else if (accept && (bank_en != '0)) begin
                            bank_q <= bankIdxW'(first_en);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_adc_readout.sv
// Directed bench for qracc_adc_readout with a beat scoreboard.
module tb_qracc_adc_readout;

    localparam int NC    = 8;
    localparam int NA    = 4;
    localparam int NB    = 8;
    localparam int CC    = 15;
    localparam int BUS_W = CC * NC * NB;

    logic             CLK;
    logic             nRST;
    logic [BUS_W-1:0] ADC_OUT;
    logic             adc_sample;
    logic [NB-1:0]    bank_en;
    logic             out_valid;
    logic             out_ready;
    logic [NC*NA-1:0] out_data;
    logic [NC-1:0]    out_bubble;
    logic [2:0]       out_bank;
    logic             out_last;
    logic             frame_done;
    logic             busy;
    logic             overrun;
    logic             clr_overrun;

    typedef struct {
        int          bank;
        logic [31:0] data;
        logic [7:0]  bubble;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    qracc_adc_readout #(
        .numCols    (NC),
        .numAdcBits (NA),
        .numBanks   (NB)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ADC_OUT     (ADC_OUT),
        .adc_sample  (adc_sample),
        .bank_en     (bank_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_bubble  (out_bubble),
        .out_bank    (out_bank),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int code_of(input int mode, input int b, input int c);
        int v;
        case (mode)
            0:       v = (b + c > 15) ? 15 : b + c;
            1:       v = (b * 3 + c * 5) % 16;
            default: v = (b + 2 * c + 7) % 16;
        endcase
        return v;
    endfunction

    function automatic logic [BUS_W-1:0] make_bus(input int mode);
        logic [BUS_W-1:0] bus;
        logic [15:0]      t;
        bus = '0;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < NC; c++) begin
                t = (16'd1 << code_of(mode, b, c)) - 16'd1;
                bus[(b*NC+c)*CC +: CC] = t[14:0];
            end
        end
        return bus;
    endfunction

    function automatic logic [BUS_W-1:0] random_bus();
        logic [BUS_W-1:0] bus;
        for (int i = 0; i < BUS_W / 32; i++) bus[i*32 +: 32] = $urandom();
        return bus;
    endfunction

    // Expected beats: popcount per column, bubble when bits are not a clean 2^n-1.
    task automatic push_expected(input logic [BUS_W-1:0] bus, input logic [NB-1:0] mask);
        beat_t       bt;
        logic [14:0] col;
        logic [15:0] t;
        int          pc;
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) begin
                bt.bank = b;
                bt.data = '0;
                bt.bubble = '0;
                for (int c = 0; c < NC; c++) begin
                    col = bus[(b*NC+c)*CC +: CC];
                    pc  = $countones(col);
                    t   = (16'd1 << pc) - 16'd1;
                    bt.data[c*NA +: NA] = 4'(pc);
                    bt.bubble[c]        = (16'(col) != t);
                end
                bt.last = ((mask >> (b + 1)) == 0);
                sb.push_back(bt);
            end
        end
    endtask

    task automatic send_sample(input logic [BUS_W-1:0] bus, input logic [NB-1:0] mask);
        ADC_OUT    = bus;
        bank_en    = mask;
        adc_sample = 1'b1;
        push_expected(bus, mask);
        tick();
        adc_sample = 1'b0;
        ADC_OUT    = random_bus();
        chk("first_valid", out_valid, (mask != 0));
        chk("first_busy", busy, (mask != 0));
    endtask

    task automatic check_beat();
        chk("beat_bank", out_bank, sb[0].bank);
        chk("beat_data", out_data, sb[0].data);
        chk("beat_bubble", out_bubble, sb[0].bubble);
        chk("beat_last", out_last, sb[0].last);
    endtask

    // mode 0: always ready, 1: ready toggles. strobe_beat: drop a strobe on that handshake.
    task automatic drain(input int mode, input int strobe_beat, input bit chain,
                         input logic [BUS_W-1:0] chain_bus, input logic [NB-1:0] chain_mask,
                         input int max_beats);
        int cyc    = 0;
        int popped = 0;
        bit pend   = chain;
        bit just;
        while (sb.size() > 0 && popped < max_beats && cyc < 400) begin
            out_ready  = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            just       = 1'b0;
            adc_sample = 1'b0;
            if (out_valid) begin
                check_beat();
                if (out_ready) begin
                    if (pend && sb[0].last) begin
                        ADC_OUT    = chain_bus;
                        bank_en    = chain_mask;
                        adc_sample = 1'b1;
                        pend       = 1'b0;
                        just       = 1'b1;
                    end else if (popped == strobe_beat) begin
                        ADC_OUT    = random_bus();
                        bank_en    = 8'hFF;
                        adc_sample = 1'b1;
                    end
                    void'(sb.pop_front());
                    popped++;
                    if (just) push_expected(chain_bus, chain_mask);
                end
            end
            tick();
            cyc++;
            adc_sample = 1'b0;
            if (just) begin
                chk("b2b_valid", out_valid, 1);
                chk("b2b_frame_done", frame_done, 1);
                ADC_OUT = random_bus();
            end
        end
        out_ready = 1'b0;
        chk("drain_in_budget", (cyc < 400), 1);
    endtask

    task automatic check_frame_end();
        chk("end_frame_done", frame_done, 1);
        chk("end_valid", out_valid, 0);
        chk("end_busy", busy, 0);
        tick();
        chk("end_frame_done_drop", frame_done, 0);
    endtask

    initial begin
        logic [BUS_W-1:0] bus;

        nRST        = 1'b0;
        ADC_OUT     = '0;
        adc_sample  = 1'b0;
        bank_en     = '0;
        out_ready   = 1'b0;
        clr_overrun = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_bubble", out_bubble, 0);
        chk("rst_bank", out_bank, 0);
        chk("rst_last", out_last, 0);
        nRST = 1'b1;
        tick();

        // Full frame, all banks, no backpressure.
        send_sample(make_bus(0), 8'hFF);
        chk("f1_b0_c3", out_data[15:12], 3);
        drain(0, -1, 1'b0, '0, '0, 100);
        check_frame_end();

        // Masked frame with toggling ready.
        send_sample(make_bus(1), 8'b1010_0100);
        chk("mask_first_bank", out_bank, 2);
        drain(1, -1, 1'b0, '0, '0, 100);
        check_frame_end();

        // Empty mask.
        send_sample(make_bus(2), 8'h00);
        chk("empty_frame_done", frame_done, 1);
        tick();
        chk("empty_frame_done_drop", frame_done, 0);
        chk("empty_valid", out_valid, 0);
        chk("empty_busy", busy, 0);

        // Bubble, all-ones and all-zeros columns.
        bus = make_bus(2);
        bus[0 +: CC]  = 15'b000_0000_0000_0101;
        bus[CC +: CC] = '1;
        bus[2*CC +: CC] = '0;
        send_sample(bus, 8'h01);
        chk("bub_code", out_data[3:0], 2);
        chk("bub_flag", out_bubble[0], 1);
        chk("ones_code", out_data[7:4], 15);
        chk("ones_flag", out_bubble[1], 0);
        chk("zeros_code", out_data[11:8], 0);
        chk("zeros_flag", out_bubble[2], 0);
        drain(0, -1, 1'b0, '0, '0, 100);
        check_frame_end();

        // Dropped strobe mid-frame, then back-to-back frames.
        chk("pre_overrun", overrun, 0);
        send_sample(make_bus(1), 8'hFF);
        drain(0, 2, 1'b0, '0, '0, 100);
        chk("overrun_set", overrun, 1);
        check_frame_end();
        send_sample(make_bus(0), 8'hFF);
        drain(0, -1, 1'b1, make_bus(2), 8'hFF, 100);
        check_frame_end();
        chk("overrun_sticky", overrun, 1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("overrun_clr", overrun, 0);

        // Reset in the middle of a frame.
        send_sample(make_bus(0), 8'hFF);
        drain(0, 1, 1'b0, '0, '0, 3);
        chk("mid_overrun", overrun, 1);
        chk("mid_bank", out_bank, 3);
        nRST = 1'b0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_frame_done", frame_done, 0);
        sb.delete();
        tick();
        chk("mrst_no_done", frame_done, 0);
        nRST = 1'b1;
        tick();
        send_sample(make_bus(1), 8'b0001_1000);
        drain(0, -1, 1'b0, '0, '0, 100);
        check_frame_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
